reg_file_8x8: RTL and testbench

// Eight-entry general-purpose register file (A..H) for the tau datapath. Drives all eight

---
 rtl/reg_file_8x8.sv | 109 ++++++++++
 tb/tb_reg_file_8x8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8.sv
// Eight-entry register file (A..H) for the tau datapath: parallel register outputs,
// single-cycle WRITE/INCDEC and a two-cycle SWAP under a valid/ready handshake.
module reg_file_8x8 #(
    parameter int                   WORD_SIZE   = 8,
    parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [1:0]           op,
    input  logic [2:0]           dst_sel,
    input  logic [2:0]           src_sel,
    input  logic                 dec,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic [WORD_SIZE-1:0] A,
    output logic [WORD_SIZE-1:0] B,
    output logic [WORD_SIZE-1:0] C,
    output logic [WORD_SIZE-1:0] D,
    output logic [WORD_SIZE-1:0] E,
    output logic [WORD_SIZE-1:0] F,
    output logic [WORD_SIZE-1:0] G,
    output logic [WORD_SIZE-1:0] H,
    output logic                 wrap,
    output logic                 state_dbg
);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SWAP   = 2'b10;
    localparam logic [1:0] OP_INCDEC = 2'b11;

    localparam logic [WORD_SIZE-1:0] ONE  = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] ONES = '1;

    typedef enum logic {IDLE = 1'b0, SWAP2 = 1'b1} state_t;

    state_t               state, state_d;
    logic [WORD_SIZE-1:0] regs [8];
    logic [WORD_SIZE-1:0] tmp;
    logic [2:0]           src_q;
    logic                 accept;
    logic                 inc_wraps;

    // Handshake: an op transfers on a rising edge where op_valid && op_ready; op_ready
    // depends on state only, so the requester may hold op_valid until it is taken.
    assign op_ready  = (state == IDLE);
    assign accept    = op_valid && op_ready;
    assign state_dbg = state;

    assign inc_wraps = dec ? (regs[dst_sel] == '0) : (regs[dst_sel] == ONES);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept && op == OP_SWAP) state_d = SWAP2;
            SWAP2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // At most one register is written per edge: SWAP2 writeback and IDLE ops are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= RESET_VALUE;
            tmp   <= '0;
            src_q <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (state == SWAP2) begin
                regs[src_q] <= tmp;
            end else if (accept) begin
                case (op)
                    OP_WRITE: regs[dst_sel] <= wr_data;
                    OP_INCDEC: begin
                        regs[dst_sel] <= dec ? (regs[dst_sel] - ONE) : (regs[dst_sel] + ONE);
                        wrap          <= inc_wraps;
                    end
                    OP_SWAP: begin
                        tmp           <= regs[dst_sel];
                        regs[dst_sel] <= regs[src_sel];
                        src_q         <= src_sel;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end

    assign A = regs[0];
    assign B = regs[1];
    assign C = regs[2];
    assign D = regs[3];
    assign E = regs[4];
    assign F = regs[5];
    assign G = regs[6];
    assign H = regs[7];

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: hand-computed register contents, wrap and op_ready
// checked one time unit after each active clock edge.
module tb_reg_file_8x8;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op;
    logic [2:0] dst_sel;
    logic [2:0] src_sel;
    logic       dec;
    logic [7:0] wr_data;
    logic [7:0] a, b, c, d, e, f, g, h;
    logic       wrap;
    logic       state_dbg;

    logic [7:0] obs [8];
    logic [7:0] exp_r [8];
    int         n_vec;
    int         n_err;

    localparam logic [1:0] NOP = 2'b00, WR = 2'b01, SW = 2'b10, ID = 2'b11;

    reg_file_8x8 dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .dst_sel(dst_sel), .src_sel(src_sel), .dec(dec), .wr_data(wr_data),
        .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g), .H(h),
        .wrap(wrap), .state_dbg(state_dbg)
    );

    assign obs[0] = a;
    assign obs[1] = b;
    assign obs[2] = c;
    assign obs[3] = d;
    assign obs[4] = e;
    assign obs[5] = f;
    assign obs[6] = g;
    assign obs[7] = h;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), 32'(obs[i]), 32'(exp_r[i]));
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) exp_r[i] = 8'h00;
    endtask

    // Present one op for one edge, then drop op_valid; returns 1 time unit after the edge.
    task automatic apply(input logic [1:0] o, input logic [2:0] ds, input logic [2:0] ss,
                         input logic dn, input logic [7:0] wd);
        op_valid = 1'b1;
        op       = o;
        dst_sel  = ds;
        src_sel  = ss;
        dec      = dn;
        wr_data  = wd;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        op_valid = 1'b1;
        op       = WR;
        dst_sel  = 3'd2;
        src_sel  = 3'd0;
        dec      = 1'b0;
        wr_data  = 8'hAA;
        clear_exp();

        // 1: ops driven during reset are ignored
        repeat (3) @(posedge clk);
        #1;
        check_regs("rst");
        check("rst_wrap", 32'(wrap), 32'd0);
        op_valid = 1'b0;
        #2 rst_n = 1'b1;
        idle_cycle();
        check("rst_ready", 32'(op_ready), 32'd1);
        check_regs("rst_rel");

        // 2: back-to-back writes
        apply(WR, 3'd2, 3'd0, 1'b0, 8'h5A);
        check("wr1_ready", 32'(op_ready), 32'd1);
        apply(WR, 3'd7, 3'd0, 1'b0, 8'hFF);
        check("wr2_ready", 32'(op_ready), 32'd1);
        exp_r[2] = 8'h5A;
        exp_r[7] = 8'hFF;
        check_regs("wr");

        // 3: increment/decrement with wrap
        apply(WR, 3'd1, 3'd0, 1'b0, 8'hFF);
        apply(ID, 3'd1, 3'd0, 1'b0, 8'h00);
        check("inc_wrap_b", 32'(b), 32'h00);
        check("inc_wrap", 32'(wrap), 32'd1);
        idle_cycle();
        check("inc_wrap_gone", 32'(wrap), 32'd0);
        apply(ID, 3'd1, 3'd0, 1'b1, 8'h00);
        check("dec_wrap_b", 32'(b), 32'hFF);
        check("dec_wrap", 32'(wrap), 32'd1);
        apply(WR, 3'd1, 3'd0, 1'b0, 8'h10);
        check("wr_nowrap", 32'(wrap), 32'd0);
        apply(ID, 3'd1, 3'd0, 1'b0, 8'h00);
        check("inc_b", 32'(b), 32'h11);
        check("inc_nowrap", 32'(wrap), 32'd0);
        apply(ID, 3'd1, 3'd0, 1'b1, 8'h00);
        check("dec_b", 32'(b), 32'h10);
        check("dec_nowrap", 32'(wrap), 32'd0);
        exp_r[1] = 8'h10;
        check_regs("incdec");

        // 4: SWAP A<->E, with an op held valid through SWAP2
        apply(WR, 3'd0, 3'd0, 1'b0, 8'h12);
        apply(WR, 3'd4, 3'd0, 1'b0, 8'h34);
        apply(SW, 3'd0, 3'd4, 1'b0, 8'h00);
        check("sw_busy", 32'(op_ready), 32'd0);
        check("sw_mid_a", 32'(a), 32'h34);
        op_valid = 1'b1;
        op       = WR;
        dst_sel  = 3'd6;
        src_sel  = 3'd1;
        wr_data  = 8'h99;
        idle_cycle();
        check("sw_ready", 32'(op_ready), 32'd1);
        check("sw_held_g", 32'(g), 32'h00);
        exp_r[0] = 8'h34;
        exp_r[4] = 8'h12;
        check_regs("sw");
        idle_cycle();
        op_valid = 1'b0;
        check("held_wr_g", 32'(g), 32'h99);
        check("held_b", 32'(b), 32'h10);
        exp_r[6] = 8'h99;

        // 5: SWAP a register with itself
        apply(WR, 3'd3, 3'd0, 1'b0, 8'h77);
        apply(SW, 3'd3, 3'd3, 1'b0, 8'h00);
        check("self_busy", 32'(op_ready), 32'd0);
        check("self_d1", 32'(d), 32'h77);
        idle_cycle();
        check("self_ready", 32'(op_ready), 32'd1);
        check("self_d2", 32'(d), 32'h77);
        exp_r[3] = 8'h77;
        check_regs("self");

        // 6: reset during SWAP2 aborts the swap
        apply(SW, 3'd0, 3'd1, 1'b0, 8'h00);
        check("abort_busy", 32'(op_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        clear_exp();
        check_regs("abort");
        check("abort_ready", 32'(op_ready), 32'd1);
        idle_cycle();
        #2 rst_n = 1'b1;
        idle_cycle();
        check("abort_rel_ready", 32'(op_ready), 32'd1);
        check_regs("abort_rel");
        apply(WR, 3'd5, 3'd0, 1'b0, 8'h3C);
        exp_r[5] = 8'h3C;
        check_regs("post_rst");

        // NOP is accepted and changes nothing
        apply(NOP, 3'd5, 3'd2, 1'b0, 8'hEE);
        check("nop_ready", 32'(op_ready), 32'd1);
        check_regs("nop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
